// File: rtl/instr_mem_pipelined.sv
// Pipelined instruction store: byte-loadable memory, valid/ready fetch port,
// configurable read latency and an in-order response FIFO with credit-based
// request throttling, flush and misalignment fault reporting.
module instr_mem_pipelined #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 1,  // 1..4
  parameter int unsigned FIFO_DEPTH   = 2   // power of two, >= 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [ADDR_WIDTH-1:0] ReqAddr,
  output logic                  RespValid,
  input  logic                  RespReady,
  output logic [31:0]           RespInstr,
  output logic [ADDR_WIDTH-1:0] RespAddr,
  output logic                  RespFault,
  input  logic                  Flush,
  input  logic                  LoadEn,
  input  logic [ADDR_WIDTH-1:0] LoadAddr,
  input  logic [7:0]            LoadData
);

  localparam int unsigned MEM_BYTES = 1 << ADDR_WIDTH;
  localparam int unsigned IDX_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W     = IDX_W + 1;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic                  fault;
    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] addr;
  } fetch_t;

  logic [7:0]            r_mem [MEM_BYTES];
  logic [CNT_W-1:0]      r_outstanding;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  fetch_t                r_fifo [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] w_base;
  logic [31:0]           w_word;
  fetch_t                w_fill;
  fetch_t                w_head;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_push_v;
  fetch_t                w_push_d;

  // Credit check: a request is only taken when FIFO space is guaranteed
  assign ReqReady = rst_n && (r_outstanding < CNT_W'(FIFO_DEPTH)) && !Flush && !LoadEn;
  assign w_accept = ReqValid && ReqReady;
  assign w_pop    = RespValid && RespReady;

  // Word-aligned little-endian read; the top word never wraps across words
  assign w_base = {ReqAddr[ADDR_WIDTH-1:2], 2'b00};
  assign w_word = {r_mem[w_base | ADDR_WIDTH'(3)], r_mem[w_base | ADDR_WIDTH'(2)],
                   r_mem[w_base | ADDR_WIDTH'(1)], r_mem[w_base]};

  // Misaligned fetches are accepted but return a NOP flagged as a fault
  always_comb begin
    w_fill       = '0;
    w_fill.fault = |ReqAddr[1:0];
    w_fill.instr = w_fill.fault ? NOP_INSTR : w_word;
    w_fill.addr  = ReqAddr;
  end

  // Program-load byte write port; contents survive reset
  always_ff @(posedge clk) begin
    if (LoadEn) begin
      r_mem[LoadAddr] <= LoadData;
    end
  end

  generate
    if (READ_LATENCY == 1) begin : g_direct
      assign w_push_v = w_accept;
      assign w_push_d = w_fill;
    end else begin : g_pipe
      localparam int unsigned NS = READ_LATENCY - 1;
      logic [NS-1:0] r_v;
      fetch_t        r_d [NS];

      // Stage valids: never stall, cleared by flush
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v <= '0;
        end else if (Flush) begin
          r_v <= '0;
        end else begin
          r_v[0] <= w_accept;
          for (int i = 1; i < int'(NS); i++) begin
            r_v[i] <= r_v[i-1];
          end
        end
      end

      // Stage payloads shift alongside their valids
      always_ff @(posedge clk) begin
        r_d[0] <= w_fill;
        for (int i = 1; i < int'(NS); i++) begin
          r_d[i] <= r_d[i-1];
        end
      end

      assign w_push_v = r_v[NS-1];
      assign w_push_d = r_d[NS-1];
    end
  endgenerate

  // Response FIFO pointers; flush empties the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (Flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_v) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Response FIFO storage
  always_ff @(posedge clk) begin
    if (w_push_v && !Flush) begin
      r_fifo[r_wr_ptr[IDX_W-1:0]] <= w_push_d;
    end
  end

  // Outstanding fetch credits: pipeline plus FIFO occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else if (Flush) begin
      r_outstanding <= '0;
    end else if (w_accept && !w_pop) begin
      r_outstanding <= r_outstanding + CNT_W'(1);
    end else if (!w_accept && w_pop) begin
      r_outstanding <= r_outstanding - CNT_W'(1);
    end
  end

  assign w_head    = r_fifo[r_rd_ptr[IDX_W-1:0]];
  assign RespValid = (r_wr_ptr != r_rd_ptr);
  assign RespInstr = RespValid ? w_head.instr : 32'h0;
  assign RespAddr  = RespValid ? w_head.addr  : '0;
  assign RespFault = RespValid && w_head.fault;

endmodule

// File: tb/tb_instr_mem_pipelined.sv
// Scoreboard bench for instr_mem_pipelined: random and directed fetch traffic,
// loads, flushes and resets checked against a transaction-level model.
module tb_instr_mem_pipelined;

  localparam int unsigned AW = 8;
  localparam int unsigned RL = 3;
  localparam int unsigned FD = 4;
  localparam int          MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ReqValid = 1'b0;
  logic          ReqReady;
  logic [AW-1:0] ReqAddr = '0;
  logic          RespValid;
  logic          RespReady = 1'b0;
  logic [31:0]   RespInstr;
  logic [AW-1:0] RespAddr;
  logic          RespFault;
  logic          Flush = 1'b0;
  logic          LoadEn = 1'b0;
  logic [AW-1:0] LoadAddr = '0;
  logic [7:0]    LoadData = '0;

  always #5 clk = ~clk;

  instr_mem_pipelined #(.ADDR_WIDTH(AW), .READ_LATENCY(RL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddr(ReqAddr),
    .RespValid(RespValid), .RespReady(RespReady), .RespInstr(RespInstr),
    .RespAddr(RespAddr), .RespFault(RespFault),
    .Flush(Flush), .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData)
  );

  typedef struct {
    logic [31:0]   instr;
    logic [AW-1:0] addr;
    logic          fault;
    int            vis;   // edge count after which the response may be seen
  } exp_t;

  exp_t       q[$];
  logic [7:0] m_mem [MEMSZ];
  int         m_out = 0;
  int         cyc = 0;
  bit         pop_seen = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input int a);
    int b;
    b = a - (a % 4);
    return {m_mem[b+3], m_mem[b+2], m_mem[b+1], m_mem[b]};
  endfunction

  // Reference model: what each rising edge does at transaction level
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_out    = 0;
      pop_seen = 1'b0;
    end else begin
      bit   acc;
      exp_t e;
      cyc++;
      acc = ReqValid && (m_out < int'(FD)) && !Flush && !LoadEn;
      if (Flush) begin
        q.delete();
        m_out = 0;
      end else begin
        if (acc) begin
          e.addr  = ReqAddr;
          e.fault = (int'(ReqAddr) % 4) != 0;
          e.instr = e.fault ? 32'h0000_0013 : model_word(int'(ReqAddr));
          e.vis   = cyc + int'(RL) - 1;
          q.push_back(e);
        end
        m_out = m_out + (acc ? 1 : 0) - (pop_seen ? 1 : 0);
      end
      if (LoadEn) m_mem[LoadAddr] = LoadData;
      pop_seen = 1'b0;
    end
  end

  // Monitor: compares DUT outputs mid-cycle and retires popped responses
  always @(negedge clk) begin
    bit exp_rr;
    bit exp_rv;
    exp_rr = rst_n && (m_out < int'(FD)) && !Flush && !LoadEn;
    exp_rv = rst_n && (q.size() > 0) && (q[0].vis <= cyc);
    check("req_ready", 64'(ReqReady), 64'(exp_rr));
    check("resp_valid", 64'(RespValid), 64'(exp_rv));
    if (exp_rv) begin
      check("resp_instr", 64'(RespInstr), 64'(q[0].instr));
      check("resp_addr", 64'(RespAddr), 64'(q[0].addr));
      check("resp_fault", 64'(RespFault), 64'(q[0].fault));
      if (RespReady) begin
        void'(q.pop_front());
        pop_seen = 1'b1;
      end
    end else if (!rst_n) begin
      check("reset_instr", 64'(RespInstr), 64'd0);
      check("reset_addr", 64'(RespAddr), 64'd0);
      check("reset_fault", 64'(RespFault), 64'd0);
    end
  end

  // Drive one cycle of inputs, then advance to just after the next edge
  task automatic step(input bit rv, input int addr, input bit rr,
                      input bit fl = 1'b0, input bit le = 1'b0,
                      input int la = 0, input int ld = 0);
    ReqValid  = rv;
    ReqAddr   = AW'(addr);
    RespReady = rr;
    Flush     = fl;
    LoadEn    = le;
    LoadAddr  = AW'(la);
    LoadData  = 8'(ld);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, 64'(ReqReady), 64'd0);
    check({tag, "_resp_valid"}, 64'(RespValid), 64'd0);
    check({tag, "_resp_instr"}, 64'(RespInstr), 64'd0);
    check({tag, "_resp_addr"}, 64'(RespAddr), 64'd0);
    check({tag, "_resp_fault"}, 64'(RespFault), 64'd0);
  endtask

  initial begin
    logic [7:0] prog [4];
    int         waited;
    prog[0] = 8'h13; prog[1] = 8'h05; prog[2] = 8'hA0; prog[3] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Program load: known first word, random elsewhere
    for (int i = 0; i < MEMSZ; i++) begin
      step(1'b0, 0, 1'b1, 1'b0, 1'b1, i, (i < 4) ? int'(prog[i]) : int'($urandom_range(0, 255)));
    end
    idle(2);

    // Single aligned fetch of the known word
    step(1'b1, 'h000, 1'b1);
    idle(5);

    // Back-to-back fetches with a ready consumer
    step(1'b1, 'h000, 1'b1);
    step(1'b1, 'h004, 1'b1);
    step(1'b1, 'h008, 1'b1);
    idle(6);

    // Back-pressure: credits run out, payload must hold
    for (int k = 0; k < 8; k++) step(1'b1, 4 * k + 'h40, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, 0, 1'b1);

    // Misaligned fetch
    step(1'b1, 'h006, 1'b1);
    idle(5);

    // Flush with two fetches in flight; request during flush is refused
    step(1'b1, 'h020, 1'b1);
    step(1'b1, 'h024, 1'b1);
    step(1'b1, 'h028, 1'b1, 1'b1);
    idle(5);
    step(1'b1, 'h020, 1'b1);
    idle(5);

    // Load after accept: in-flight fetch keeps old data, refetch sees new
    step(1'b1, 'h010, 1'b1);
    step(1'b1, 'h014, 1'b1, 1'b0, 1'b1, 'h010, 'h5A);
    idle(5);
    step(1'b1, 'h010, 1'b1);
    idle(5);

    // Top word and misaligned top byte
    step(1'b1, MEMSZ - 4, 1'b1);
    step(1'b1, MEMSZ - 1, 1'b1);
    idle(5);

    // Flush together with a load
    step(1'b1, 'h030, 1'b1);
    step(1'b0, 0, 1'b1, 1'b1, 1'b1, 'h031, 'hC3);
    idle(4);
    step(1'b1, 'h030, 1'b1);
    idle(5);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, int'($urandom_range(0, MEMSZ - 1)), ($urandom % 3) != 0,
           ($urandom % 40) == 0, ($urandom % 16) == 0,
           int'($urandom_range(0, MEMSZ - 1)), int'($urandom_range(0, 255)));
    end

    // Drain with a bounded wait
    waited = 0;
    while ((q.size() != 0 || m_out != 0) && waited < 64) begin
      step(1'b0, 0, 1'b1);
      waited++;
    end
    check("drain_queue", 64'(q.size()), 64'd0);
    check("drain_outstanding", 64'(m_out), 64'd0);

    // Reset mid-operation with fetches outstanding
    step(1'b1, 'h040, 1'b0);
    step(1'b1, 'h044, 1'b0);
    rst_n = 1'b0;
    q.delete();
    m_out    = 0;
    pop_seen = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(posedge clk);
    #1;
    step(1'b0, 0, 1'b1);
    rst_n = 1'b1;
    idle(10);
    step(1'b1, 'h000, 1'b1);
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_pipelined.md
Name: instr_mem_pipelined

Overview:
Parametrised, clocked successor to the combinational instruction memory. It is a byte-array instruction store with a valid/ready fetch-request port and a configurable read latency. A response FIFO preserves order and absorbs back-pressure from the decode stage. It also provides a byte-wide program-load port, a fetch flush for branch redirects, and misalignment fault reporting. It sits between the PC/fetch logic and the decode stage of the RISC-V core.

Parameters:
ADDR_WIDTH, 10, byte-address width; memory holds 2^ADDR_WIDTH bytes.
READ_LATENCY, 1, clock edges from request acceptance to response visibility; legal range 1..4.
FIFO_DEPTH, 2, maximum outstanding fetches (pipeline plus FIFO); must be at least READ_LATENCY+1 for one fetch per cycle; power of two.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
ReqValid  in  1  fetch request valid
ReqReady  out  1  fetch request accepted this cycle if ReqValid
ReqAddr  in  ADDR_WIDTH  byte address of the instruction
RespValid  out  1  response available
RespReady  in  1  consumer accepts response
RespInstr  out  32  fetched instruction, little-endian
RespAddr  out  ADDR_WIDTH  address the response belongs to
RespFault  out  1  misaligned fetch
Flush  in  1  discard all in-flight and queued fetches
LoadEn  in  1  program-load byte write enable
LoadAddr  in  ADDR_WIDTH  load byte address
LoadData  in  8  load byte

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline valids cleared, FIFO empty, outstanding count 0.
  - RespValid=0, RespInstr=0, RespAddr=0, RespFault=0, ReqReady=0 while in reset.
  - Memory contents are not reset.
  - Reset mid-operation drops all fetches; no partial response is ever emitted.
- ReqReady = (outstanding < FIFO_DEPTH) && !Flush && !LoadEn.
  - Purely registered-state based; no combinational path from RespReady or ReqValid.
- Acceptance: ReqValid && ReqReady at a rising edge.
  - Memory is sampled at that edge: {mem[A|3], mem[A|2], mem[A|1], mem[A|0]}, where A = ReqAddr with bits [1:0] forced to 00.
  - ReqAddr is captured as RespAddr.
- Latency: the entry traverses READ_LATENCY-1 further register stages, then enters the FIFO.
  - With an empty FIFO, RespValid rises in the cycle after READ_LATENCY rising edges, counting the accept edge.
  - READ_LATENCY=1 gives a response in the cycle immediately after acceptance.
- Misalignment: ReqAddr[1:0] != 0 is still accepted. The response carries RespFault=1 and RespInstr=32'h00000013 (NOP).
- Ordering: responses leave strictly in acceptance order.
  - Pop on RespValid && RespReady.
  - RespInstr, RespAddr and RespFault hold stable while RespValid && !RespReady.
- Outstanding count:
  - +1 on accept, −1 on pop, unchanged on simultaneous accept and pop.
  - Never exceeds FIFO_DEPTH; never underflows.
  - Pipeline stages never stall, because credits guarantee FIFO space.
- Flush (synchronous, sampled at edge):
  - Clears all pipeline valids and the FIFO; outstanding becomes 0.
  - RespValid=0 from the next cycle.
  - A pop coincident with Flush is still a completed handshake.
  - No request is accepted in a Flush cycle.
- Load port: LoadEn writes LoadData to mem[LoadAddr] at the edge.
  - Blocks new requests that cycle.
  - Fetches already accepted keep the data sampled at acceptance.
- Address wrap: ADDR_WIDTH-bit arithmetic only; the top word (A = 2^ADDR_WIDTH−4) reads its own four bytes with no wrap across words.
- Flush and LoadEn together: both take effect.

Test Plan:
1. Reset then load bytes 13 05 A0 00 at 0x000..0x003; READ_LATENCY=1; request 0x000 → next cycle RespValid=1, RespInstr=32'h00A00513, RespAddr=0, RespFault=0.
2. READ_LATENCY=3, FIFO_DEPTH=4, RespReady=1; back-to-back requests 0x000, 0x004, 0x008 → ReqReady held 1; responses on three consecutive cycles, first 3 cycles after accept, addresses in order.
3. RespReady=0, FIFO_DEPTH=2, keep ReqValid=1 → exactly 2 accepts, then ReqReady=0 with RespInstr stable; raise RespReady → one pop per cycle, ReqReady returns 1 the cycle after the first pop.
4. Request 0x006 → RespFault=1, RespInstr=32'h00000013, RespAddr=0x006.
5. Two fetches in flight (READ_LATENCY=2), assert Flush one cycle → no RespValid for either; ReqReady=0 during Flush, 1 next cycle; the next request returns correct data.
6. Accept fetch of 0x010, then LoadEn overwrites 0x010 the next cycle → response shows old word; refetch shows new word. Drop rst_n with 2 outstanding → all outputs 0 immediately; nothing emitted after release.
